// File: rtl/vend_dispense_sequencer.sv
// vend_dispense_sequencer
//
// Runs one complete vend after the vending controller has charged a purchase.
// A request lights the product's dispense LED for DISPENSE_TICKS cycles. It then
// pays the change owed, one coin per cycle, always the largest coin that fits
// (quarter, then dime, then nickel). It ends with a one-cycle vend_ack. A request
// whose change is not a multiple of 5, or is above MAX_CHANGE, is rejected with a
// one-cycle err pulse.
//
// Ports
//   clk_1Hz      in   sequencer tick (1 Hz clock enable domain)
//   clr          in   asynchronous, active-high reset
//   vend_req     in   one-cycle request, sampled only while idle
//   product[1:0] in   product index, sampled with vend_req
//   change_in[7:0] in change owed in cents, sampled with vend_req
//   busy         out  high from acceptance through the ack cycle
//   product_led[3:0] out one-hot dispense LED
//   coin_q/d/n   out  one-cycle quarter / dime / nickel pay-out pulses
//   change_left[7:0] out change still to be paid
//   vend_ack     out  one-cycle pulse at sequence completion
//   err          out  one-cycle pulse for a rejected request
//
// Every output is a flop. The comb blocks compute the values that the outputs take
// after the next edge.

module vend_dispense_sequencer #(
  parameter int unsigned DISPENSE_TICKS = 2,
  parameter int unsigned MAX_CHANGE     = 35
) (
  input  logic       clk_1Hz,
  input  logic       clr,
  input  logic       vend_req,
  input  logic [1:0] product,
  input  logic [7:0] change_in,
  output logic       busy,
  output logic [3:0] product_led,
  output logic       coin_q,
  output logic       coin_d,
  output logic       coin_n,
  output logic [7:0] change_left,
  output logic       vend_ack,
  output logic       err
);

  localparam logic [3:0] TicksInit = 4'(DISPENSE_TICKS - 1);
  localparam logic [7:0] MaxChange = 8'(MAX_CHANGE);

  typedef enum logic [2:0] {
    StIdle,
    StDispense,
    StChange,
    StDone,
    StError
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic       busy_d;
  logic [3:0] product_led_d;
  logic       coin_q_d, coin_d_d, coin_n_d;
  logic [7:0] change_left_d;
  logic       vend_ack_d, err_d;

  logic req_ok;
  logic pay;

  assign req_ok = ((change_in % 8'd5) == 8'd0) && (change_in <= MaxChange);

  // The coin is chosen on the edge that leaves DISPENSE. This puts the first coin in
  // the cycle right after the LED goes dark. The same choice is made on every edge
  // while in CHANGE.
  assign pay = ((state_q == StDispense) && (cnt_q == 4'd0)) || (state_q == StChange);

  // State and output registers
  always_ff @(posedge clk_1Hz or posedge clr) begin
    if (clr) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      busy        <= 1'b0;
      product_led <= 4'd0;
      coin_q      <= 1'b0;
      coin_d      <= 1'b0;
      coin_n      <= 1'b0;
      change_left <= 8'd0;
      vend_ack    <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy        <= busy_d;
      product_led <= product_led_d;
      coin_q      <= coin_q_d;
      coin_d      <= coin_d_d;
      coin_n      <= coin_n_d;
      change_left <= change_left_d;
      vend_ack    <= vend_ack_d;
      err         <= err_d;
    end
  end

  // Next state and tick counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (vend_req) begin
          if (req_ok) begin
            state_d = StDispense;
            cnt_d   = TicksInit;
          end else begin
            state_d = StError;
          end
        end
      end
      StDispense: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = (change_left != 8'd0) ? StChange : StDone;
        end
      end
      // change_left already reflects the coin shown in this cycle.
      StChange: begin
        if (change_left == 8'd0) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      StError: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Next registered output values
  always_comb begin
    busy_d        = 1'b0;
    product_led_d = 4'd0;
    coin_q_d      = 1'b0;
    coin_d_d      = 1'b0;
    coin_n_d      = 1'b0;
    change_left_d = 8'd0;
    vend_ack_d    = 1'b0;
    err_d         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (vend_req) begin
          if (req_ok) begin
            busy_d        = 1'b1;
            product_led_d = 4'b0001 << product;
            change_left_d = change_in;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StDispense, StChange: begin
        busy_d        = 1'b1;
        change_left_d = change_left;
        if (!pay) begin
          product_led_d = product_led;
        end else if (change_left >= 8'd25) begin
          coin_q_d      = 1'b1;
          change_left_d = change_left - 8'd25;
        end else if (change_left >= 8'd10) begin
          coin_d_d      = 1'b1;
          change_left_d = change_left - 8'd10;
        end else if (change_left != 8'd0) begin
          coin_n_d      = 1'b1;
          change_left_d = change_left - 8'd5;
        end else begin
          vend_ack_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vend_dispense_sequencer.sv
// Bench for vend_dispense_sequencer. When a request is accepted, a model in the bench
// builds the full list of per-cycle output values that the vend must produce. It
// then replays that list one entry per clock, and a compare process checks every
// cycle. Each directed vend also checks DUT pulse counts against hand-computed
// totals.

module tb_vend_dispense_sequencer;

  localparam int unsigned Ticks = 2;
  localparam int unsigned MaxCh = 35;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       vend_req = 1'b0;
  logic [1:0] product = 2'd0;
  logic [7:0] change_in = 8'd0;
  logic       busy, coin_q, coin_d, coin_n, vend_ack, err;
  logic [3:0] product_led;
  logic [7:0] change_left;

  vend_dispense_sequencer #(
    .DISPENSE_TICKS(Ticks),
    .MAX_CHANGE    (MaxCh)
  ) dut (
    .clk_1Hz    (clk),
    .clr        (clr),
    .vend_req   (vend_req),
    .product    (product),
    .change_in  (change_in),
    .busy       (busy),
    .product_led(product_led),
    .coin_q     (coin_q),
    .coin_d     (coin_d),
    .coin_n     (coin_n),
    .change_left(change_left),
    .vend_ack   (vend_ack),
    .err        (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct packed {
    logic       busy;
    logic [3:0] led;
    logic       cq, cd, cn;
    logic [7:0] cl;
    logic       ack, err;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_cur = '0;
  bit   in_idle = 1'b1;

  function automatic void build(input logic [1:0] p, input logic [7:0] c);
    exp_t e;
    int   rem;
    if ((int'(c) % 5) != 0 || int'(c) > int'(MaxCh)) begin
      e = '0;
      e.err = 1'b1;
      exp_q.push_back(e);
      return;
    end
    for (int i = 0; i < int'(Ticks); i++) begin
      e = '0;
      e.busy = 1'b1;
      e.led  = 4'(1 << p);
      e.cl   = c;
      exp_q.push_back(e);
    end
    rem = int'(c);
    while (rem > 0) begin
      e = '0;
      e.busy = 1'b1;
      if (rem >= 25) begin
        e.cq = 1'b1; rem -= 25;
      end else if (rem >= 10) begin
        e.cd = 1'b1; rem -= 10;
      end else begin
        e.cn = 1'b1; rem -= 5;
      end
      e.cl = 8'(rem);
      exp_q.push_back(e);
    end
    e = '0;
    e.busy = 1'b1;
    e.ack  = 1'b1;
    exp_q.push_back(e);
  endfunction

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      exp_q.delete();
      exp_cur = '0;
      in_idle = 1'b1;
    end else if (in_idle && vend_req) begin
      build(product, change_in);
      exp_cur = exp_q.pop_front();
      in_idle = 1'b0;
    end else if (exp_q.size() > 0) begin
      exp_cur = exp_q.pop_front();
    end else begin
      exp_cur = '0;
      in_idle = 1'b1;
    end
  end

  // ---------------- per-cycle compare and tallies ----------------
  int n_busy, n_led, n_q, n_d, n_n, n_ack, n_err;

  always @(negedge clk) begin
    chk("busy", busy, exp_cur.busy);
    chk("product_led", product_led, exp_cur.led);
    chk("coin_q", coin_q, exp_cur.cq);
    chk("coin_d", coin_d, exp_cur.cd);
    chk("coin_n", coin_n, exp_cur.cn);
    chk("change_left", change_left, exp_cur.cl);
    chk("vend_ack", vend_ack, exp_cur.ack);
    chk("err", err, exp_cur.err);
    chk("one_coin_max", int'(coin_q) + int'(coin_d) + int'(coin_n) <= 1, 1);
    n_busy += int'(busy);
    n_led  += int'(product_led != 4'd0);
    n_q    += int'(coin_q);
    n_d    += int'(coin_d);
    n_n    += int'(coin_n);
    n_ack  += int'(vend_ack);
    n_err  += int'(err);
  end

  task automatic clear_tally();
    n_busy = 0; n_led = 0; n_q = 0; n_d = 0; n_n = 0; n_ack = 0; n_err = 0;
  endtask

  task automatic tally(input string tag, input int b, input int l, input int q,
                       input int d, input int n, input int a, input int e);
    chk({tag, "_busy_cycles"}, n_busy, b);
    chk({tag, "_led_cycles"}, n_led, l);
    chk({tag, "_quarters"}, n_q, q);
    chk({tag, "_dimes"}, n_d, d);
    chk({tag, "_nickels"}, n_n, n);
    chk({tag, "_acks"}, n_ack, a);
    chk({tag, "_errs"}, n_err, e);
  endtask

  task automatic vend(input logic [1:0] p, input logic [7:0] c);
    @(negedge clk);
    clear_tally();
    vend_req  = 1'b1;
    product   = p;
    change_in = c;
    @(negedge clk);
    vend_req  = 1'b0;
    change_in = 8'd0;
    repeat (10) @(negedge clk);
  endtask

  task automatic outputs_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_led"}, product_led, 0);
    chk({tag, "_coins"}, int'(coin_q) + int'(coin_d) + int'(coin_n), 0);
    chk({tag, "_change_left"}, change_left, 0);
    chk({tag, "_ack_err"}, int'(vend_ack) + int'(err), 0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    clear_tally();
    #1 clr = 1'b1;
    repeat (2) @(negedge clk);
    outputs_zero("reset");
    #2 clr = 1'b0;
    repeat (2) @(negedge clk);

    //         prod  chg     busy led  q  d  n  ack err
    vend(2'd2, 8'd0);  tally("v0",  3, 2, 0, 0, 0, 1, 0);
    vend(2'd0, 8'd35); tally("v35", 5, 2, 1, 1, 0, 1, 0);
    vend(2'd1, 8'd30); tally("v30", 5, 2, 1, 0, 1, 1, 0);
    vend(2'd3, 8'd20); tally("v20", 5, 2, 0, 2, 0, 1, 0);
    vend(2'd2, 8'd15); tally("v15", 5, 2, 0, 1, 1, 1, 0);
    vend(2'd1, 8'd12); tally("v12", 0, 0, 0, 0, 0, 0, 1);
    vend(2'd0, 8'd40); tally("v40", 0, 0, 0, 0, 0, 0, 1);

    // A second request arriving during DISPENSE must be ignored.
    @(negedge clk);
    clear_tally();
    vend_req = 1'b1; product = 2'd0; change_in = 8'd5;
    @(negedge clk);
    vend_req = 1'b1; product = 2'd3; change_in = 8'd25;
    @(negedge clk);
    vend_req = 1'b0; change_in = 8'd0;
    repeat (10) @(negedge clk);
    tally("ignore", 4, 2, 0, 0, 1, 1, 0);

    // Asynchronous clear during CHANGE, after the quarter.
    @(negedge clk);
    clear_tally();
    vend_req = 1'b1; product = 2'd0; change_in = 8'd35;
    @(negedge clk);
    vend_req = 1'b0; change_in = 8'd0;
    repeat (2) @(negedge clk);
    chk("abort_pre_quarter", coin_q, 1);
    #2 clr = 1'b1;
    #1 outputs_zero("abort");
    @(negedge clk);
    #2 clr = 1'b0;
    repeat (6) @(negedge clk);
    tally("abort", 3, 2, 1, 0, 0, 0, 0);

    vend(2'd1, 8'd5); tally("after", 4, 2, 0, 0, 1, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vend_dispense_sequencer.md
Name: vend_dispense_sequencer

Overview:
- Downstream of the vending controller. Runs one complete vend after the controller charges a purchase.
- Accepts one vend request carrying the purchased product index and the change owed in cents.
- Lights the product's dispense LED for a fixed number of ticks, then pays out change one coin per tick using greedy selection (quarter, then dime, then nickel).
- Asserts busy for the whole sequence so the controller withholds further requests.

Parameters:
- DISPENSE_TICKS, 2, number of clk_1Hz cycles the product LED stays lit (legal range 1..15).
- MAX_CHANGE, 35, largest legal change_in value in cents.

Ports:
- clk_1Hz  input  1  sequencer clock; 1 Hz tick from the clock-enable divider.
- clr  input  1  reset.
- vend_req  input  1  one-cycle request; sampled only in IDLE.
- product  input  2  product index 0..3, sampled together with vend_req.
- change_in  input  8  change owed in cents (binary), sampled together with vend_req.
- busy  output  1  high from the edge that accepts a request through the DONE cycle.
- product_led  output  4  one-hot dispense LED, bit = product.
- coin_q  output  1  one-cycle quarter (25) pay-out pulse.
- coin_d  output  1  one-cycle dime (10) pay-out pulse.
- coin_n  output  1  one-cycle nickel (5) pay-out pulse.
- change_left  output  8  remaining change to pay, binary.
- vend_ack  output  1  one-cycle pulse marking sequence complete.
- err  output  1  one-cycle pulse marking a rejected request.

Behaviour:
- Reset: clr is asynchronous, active-high; clock clk_1Hz.
  - While clr is high: state=IDLE; busy, product_led, coin_q/d/n, vend_ack, err = 0; change_left = 0; tick counter = 0.
- All outputs are registered. No combinational path from inputs to outputs.
- States: IDLE, DISPENSE, CHANGE, DONE, ERROR.
- IDLE
  - vend_req=0: stay; all outputs 0.
  - vend_req=1 with change_in a multiple of 5 and change_in<=MAX_CHANGE: next edge enters DISPENSE.
    - busy=1; product_led=1<<product; change_left=change_in; tick counter=DISPENSE_TICKS-1.
  - vend_req=1 with change_in%5!=0 or change_in>MAX_CHANGE: next edge enters ERROR with err=1. No LED, no coins.
- DISPENSE
  - product_led held while the counter counts down, so the LED is high exactly DISPENSE_TICKS cycles.
  - When counter=0: product_led cleared. Go to CHANGE if change_left>0, else DONE.
- CHANGE: exactly one coin per cycle, chosen on the edge.
  - change_left>=25: coin_q=1, change_left-=25.
  - else change_left>=10: coin_d=1, change_left-=10.
  - else: coin_n=1, change_left-=5.
  - At most one coin_* high in any cycle; pulses last one cycle.
  - The coin that brings change_left to 0 is issued in the last CHANGE cycle; the next edge enters DONE.
  - Coin order is always descending value.
- DONE: vend_ack=1 and busy=1 for one cycle; coins and LED are 0. Next edge goes to IDLE with busy=0.
- ERROR: err=1 for one cycle, busy=0, change_left=0. Next edge goes to IDLE.
- Latency
  - Request accepted at edge k: product_led high on cycles k+1..k+DISPENSE_TICKS.
  - First coin at k+DISPENSE_TICKS+1.
  - vend_ack one cycle after the last coin.
  - Total busy cycles = DISPENSE_TICKS + coin count + 1.
- vend_req while busy (any non-IDLE state): ignored; product and change_in are not resampled.
- vend_req held high across the return to IDLE: accepted again on the first IDLE cycle. The upstream block must pulse.
- clr mid-sequence (any state): immediate abort, all outputs 0. Remaining coins are not paid and no vend_ack is issued.
- Width: change_left is 8 bits and never underflows, because only multiples of 5 are accepted.

Test Plan:
- Reset, then vend_req with product=2, change_in=0, DISPENSE_TICKS=2 -> product_led=0100 for 2 cycles, no coins, vend_ack in cycle 3, busy high for 3 cycles.
- product=0, change_in=35 -> LED 0001 for 2 cycles, then coin_q (change_left 10), then coin_d (change_left 0), then vend_ack; busy 5 cycles.
- change_in=30 -> coin_q then coin_n; change_in=20 -> coin_d, coin_d; change_in=15 -> coin_d, coin_n. Never two coin_* high in the same cycle.
- change_in=12, then separately change_in=40 -> err pulse of 1 cycle each, product_led stays 0, no coins, busy stays 0, IDLE on the next edge.
- New vend_req with change_in=25 pulsed during DISPENSE of an active change_in=5 vend -> ignored; only one coin_n is paid, and a single vend_ack is issued.
- clr asserted between clock edges during CHANGE of change_in=35 after the coin_q pulse -> outputs 0 immediately, no coin_d, no vend_ack. After clr is released, a fresh vend with change_in=5 completes normally.
